// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// uart_prog_loader : 8N1 UART packet loader driving IROM/DRAM programming ports
// Revision: 1.0
// ============================================================================
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int WIDX_W       = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    L_CMD  = 3'd0,
    L_CNT0 = 3'd1,
    L_CNT1 = 3'd2,
    L_DATA = 3'd3,
    L_DONE = 3'd4
  } ld_state_t;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    rx_state_d   = rx_state_q;
    clk_cnt_d    = clk_cnt_q + CNT_W'(1);
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    case (rx_state_q)
      R_IDLE: begin
        clk_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = R_START;
          bit_cnt_d  = 3'd0;
        end
      end
      R_START: begin
        if (clk_cnt_q == c_HALF_LAST) begin
          clk_cnt_d  = '0;
          rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (clk_cnt_q == c_BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_state_d = R_STOP;
          end
        end
      end
      R_STOP: begin
        if (clk_cnt_q == c_BIT_LAST) begin
          clk_cnt_d  = '0;
          rx_state_d = R_IDLE;
          if (rx_s2_q) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= R_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      rx_state_q   <= rx_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet loader; shift_q is stable during the byte_valid_q cycle
  // ---------------------------------------------------------------------------
  ld_state_t         ld_state_q, ld_state_d;
  logic              region_q, region_d;
  logic [15:0]       count_q, count_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       word_q, word_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic              wen_q, wen_d;
  logic [14:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              done_q, done_d;

  always_comb begin
    ld_state_d = ld_state_q;
    region_d   = region_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    widx_d     = widx_q;
    wen_d      = 1'b0;
    adr_d      = adr_q;
    dat_d      = dat_q;
    done_d     = done_q;
    if (byte_valid_q) begin
      case (ld_state_q)
        L_CMD: begin
          case (shift_q)
            8'hA5: begin
              region_d   = 1'b0;
              ld_state_d = L_CNT0;
            end
            8'h5A: begin
              region_d   = 1'b1;
              ld_state_d = L_CNT0;
            end
            8'hFF: begin
              done_d     = 1'b1;
              ld_state_d = L_DONE;
            end
            default: ld_state_d = L_CMD;
          endcase
        end
        L_CNT0: begin
          count_d[7:0] = shift_q;
          ld_state_d   = L_CNT1;
        end
        L_CNT1: begin
          count_d    = {shift_q, count_q[7:0]};
          byte_idx_d = 2'd0;
          widx_d     = '0;
          ld_state_d = ({shift_q, count_q[7:0]} == 16'd0) ? L_CMD : L_DATA;
        end
        L_DATA: begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = shift_q;
            2'd1: word_d[15:8]  = shift_q;
            2'd2: word_d[23:16] = shift_q;
            default: begin
              wen_d   = 1'b1;
              dat_d   = {shift_q, word_q};
              adr_d   = {region_q, 14'(widx_q)};
              widx_d  = widx_q + WIDX_W'(1);
              count_d = count_q - 16'd1;
              if (count_q == 16'd1) begin
                ld_state_d = L_CMD;
              end
            end
          endcase
        end
        L_DONE: ld_state_d = L_DONE;
        default: ld_state_d = L_CMD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state_q <= L_CMD;
      region_q   <= 1'b0;
      count_q    <= 16'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 24'd0;
      widx_q     <= '0;
      wen_q      <= 1'b0;
      adr_q      <= 15'd0;
      dat_q      <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      region_q   <= region_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      widx_q     <= widx_d;
      wen_q      <= wen_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      done_q     <= done_d;
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_uart_prog_loader : randomized packet stimulus against a packet-level model
// Revision: 1.0
// ============================================================================
module tb_uart_prog_loader;

  localparam int CPB    = 16;
  localparam int WIDX_W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        frame_err;

  always #5 clk = ~clk;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .WIDX_W(WIDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o),
    .frame_err  (frame_err)
  );

  typedef struct packed {
    logic [14:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_q[$];
  logic        exp_done = 1'b0;
  logic        exp_ferr = 1'b0;
  logic        mon_en   = 1'b0;
  logic [14:0] last_adr = 15'd0;
  logic [31:0] last_dat = 32'd0;
  int          checks   = 0;
  int          passes   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic logic [14:0] model_adr(input logic region, input int idx);
    return {region, 14'(idx % (1 << WIDX_W))};
  endfunction

  // Every strobe must match the oldest outstanding expected write; between
  // strobes the address/data outputs must hold the last written pair.
  always @(negedge clk) begin
    wr_t w;
    if (rst) begin
      last_adr = 15'd0;
      last_dat = 32'd0;
    end else if (mon_en) begin
      if (upg_wen_o) begin
        check("wen_when_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("wr_adr", 64'(upg_adr_o), 64'(w.adr));
          check("wr_dat", 64'(upg_dat_o), 64'(w.dat));
          last_adr = w.adr;
          last_dat = w.dat;
        end
      end else begin
        check("hold_adr", 64'(upg_adr_o), 64'(last_adr));
        check("hold_dat", 64'(upg_dat_o), 64'(last_dat));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] cnt);
    send_byte(cmd);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
  endtask

  task automatic expect_wr(input logic [14:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_state(input string tag);
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_done"}, 64'(upg_done_o), 64'(exp_done));
    check({tag, "_ferr"}, 64'(frame_err), 64'(exp_ferr));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    exp_done = 1'b0;
    exp_ferr = 1'b0;
    tick(2);
  endtask

  // Sends a good byte, sometimes preceded by a corrupted frame that must be dropped.
  task automatic send_byte_noisy(input logic [7:0] b);
    if ($urandom_range(0, 7) == 0) begin
      send_frame(8'($urandom), 1'b0);
      exp_ferr = 1'b1;
    end
    send_byte(b);
  endtask

  task automatic rand_packet();
    logic        region;
    int          n;
    logic [31:0] w;
    logic [7:0]  junk;
    region = 1'($urandom_range(0, 1));
    n      = $urandom_range(0, 6);
    if ($urandom_range(0, 3) == 0) begin
      junk = 8'($urandom);
      if (junk == 8'hA5 || junk == 8'h5A || junk == 8'hFF) junk = 8'h3C;
      send_byte_noisy(junk);
    end
    send_byte_noisy(region ? 8'h5A : 8'hA5);
    send_byte_noisy(8'(n));
    send_byte_noisy(8'h00);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (!exp_done) expect_wr(model_adr(region, i), w);
      for (int k = 0; k < 4; k++) send_byte_noisy(w[8*k +: 8]);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    check("rst_wen",  64'(upg_wen_o),  64'd0);
    check("rst_adr",  64'(upg_adr_o),  64'd0);
    check("rst_dat",  64'(upg_dat_o),  64'd0);
    check("rst_done", 64'(upg_done_o), 64'd0);
    check("rst_ferr", 64'(frame_err),  64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(4);

    check("model_adr_wrap", 64'(model_adr(1'b1, 5)), 64'h4001);
    check("model_adr_imem", 64'(model_adr(1'b0, 3)), 64'h0003);

    // Single instruction word
    expect_wr(15'h0000, 32'h12345678);
    send_hdr(8'hA5, 16'd1);
    send_word(32'h12345678);
    check_state("t1");

    // Two data words
    expect_wr(15'h4000, 32'h00000001);
    expect_wr(15'h4001, 32'hDEADBEEF);
    send_hdr(8'h5A, 16'd2);
    send_word(32'h00000001);
    send_word(32'hDEADBEEF);
    check_state("t2");

    // Junk bytes in command position are ignored
    send_byte(8'h33);
    send_byte(8'h00);
    expect_wr(15'h0000, 32'hDDCCBBAA);
    send_hdr(8'hA5, 16'd1);
    send_word(32'hDDCCBBAA);
    check_state("t3");

    // Short low glitch is a false start
    rx = 1'b0;
    tick(CPB / 4);
    rx = 1'b1;
    tick(2 * CPB);
    check_state("glitch");

    // Corrupted frame inside a word leaves the assembly untouched
    expect_wr(15'h0000, 32'h12345678);
    send_hdr(8'hA5, 16'd1);
    send_byte(8'h78);
    send_frame(8'h99, 1'b0);
    exp_ferr = 1'b1;
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    check_state("ferr");

    // Reset mid-word discards the partial word
    send_hdr(8'hA5, 16'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    check_state("pre_rst");
    pulse_reset();
    check_state("post_rst");
    expect_wr(15'h0000, 32'h04030201);
    send_hdr(8'hA5, 16'd1);
    send_word(32'h04030201);
    check_state("t6");

    // Wrap of the word index past 2^WIDX_W
    for (int i = 0; i < 6; i++) expect_wr(model_adr(1'b0, i), 32'hC0DE0000 + 32'(i));
    send_hdr(8'hA5, 16'd6);
    for (int i = 0; i < 6; i++) send_word(32'hC0DE0000 + 32'(i));
    check_state("wrap");
    check("wrap_last_adr", 64'(last_adr), 64'h0001);

    for (int p = 0; p < 14; p++) begin
      rand_packet();
      check_state("rand");
    end

    // Done is sticky and blocks all further writes
    send_byte(8'hFF);
    exp_done = 1'b1;
    check_state("done");
    send_hdr(8'hA5, 16'd1);
    send_word(32'h44332211);
    check_state("after_done");
    pulse_reset();
    check_state("done_cleared");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
